// File: rtl/writeback_nway_pkg.sv
// Shared definitions for the writeback stage: load-select bit positions,
// load-select width and the bundle state encoding.
package writeback_nway_pkg;

   localparam int unsigned LSEL_LB  = 0;
   localparam int unsigned LSEL_LBU = 1;
   localparam int unsigned LSEL_LH  = 2;
   localparam int unsigned LSEL_LHU = 3;
   localparam int unsigned LSEL_LW  = 4;
   localparam int unsigned LSEL_LWL = 5;
   localparam int unsigned LSEL_LWR = 6;
   localparam int unsigned LSEL_W   = 7;

   typedef enum logic [1:0] {
      WB_EMPTY = 2'd0,
      WB_WAIT  = 2'd1,
      WB_READY = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// Per-lane load data extraction: byte/half/word select by address low bits,
// LWL/LWR merge with the old rt value. Loads operate on the low 32 bits.
module wb_load_align
   import writeback_nway_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned LSEL_W = writeback_nway_pkg::LSEL_W
) (
   input  logic [LSEL_W-1:0] lsel,
   input  logic [1:0]        align,
   input  logic [XLEN-1:0]   rdata,
   input  logic [XLEN-1:0]   rt,
   input  logic [XLEN-1:0]   res,
   output logic [XLEN-1:0]   wdata_c
);

   logic [31:0] word;
   logic [31:0] old;
   logic [7:0]  byte_v;
   logic [15:0] half;
   logic [31:0] lwl_w;
   logic [31:0] lwr_w;

   assign word = rdata[31:0];
   assign old  = rt[31:0];

   always_comb begin
      byte_v = word[{align, 3'b000} +: 8];
      half   = align[1] ? word[31:16] : word[15:0];
      // Little-endian unaligned merges: LWL fills from the top, LWR from the bottom.
      case (align)
         2'd0:    begin lwl_w = {word[7:0],  old[23:0]}; lwr_w = word;                     end
         2'd1:    begin lwl_w = {word[15:0], old[15:0]}; lwr_w = {old[31:24], word[31:8]};  end
         2'd2:    begin lwl_w = {word[23:0], old[7:0]};  lwr_w = {old[31:16], word[31:16]}; end
         default: begin lwl_w = word;                    lwr_w = {old[31:8],  word[31:24]}; end
      endcase

      wdata_c = res;
      if (lsel[LSEL_LB])       wdata_c = XLEN'($signed(byte_v));
      else if (lsel[LSEL_LBU]) wdata_c = XLEN'(byte_v);
      else if (lsel[LSEL_LH])  wdata_c = XLEN'($signed(half));
      else if (lsel[LSEL_LHU]) wdata_c = XLEN'(half);
      else if (lsel[LSEL_LW])  wdata_c = XLEN'(word);
      else if (lsel[LSEL_LWL]) wdata_c = XLEN'(lwl_w);
      else if (lsel[LSEL_LWR]) wdata_c = XLEN'(lwr_w);
   end

endmodule

// File: rtl/writeback_nway.sv
// Multi-lane writeback stage: holds one bundle, waits for load data, retires to
// the register file. Optional debug trace port set under WB_DEBUG_TRACE_EN.
module writeback_nway
   import writeback_nway_pkg::*;
#(
   parameter int unsigned LANES  = 2,
   parameter int unsigned XLEN   = 32,
   parameter int unsigned LSEL_W = writeback_nway_pkg::LSEL_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   input  logic                    mem_valid_i,
   output logic                    wb_allowin_o,
   input  logic                    down_allowin_i,
   input  logic [LANES-1:0]        mem_lane_en_i,
   input  logic [5*LANES-1:0]      mem_wnum_i,
   input  logic [XLEN*LANES-1:0]   mem_res_i,
   input  logic [XLEN*LANES-1:0]   mem_rt_i,
   input  logic [2*LANES-1:0]      mem_align_i,
   input  logic [LSEL_W*LANES-1:0] mem_lsel_i,
   input  logic [XLEN*LANES-1:0]   mem_pc_i,
   input  logic [LANES-1:0]        mem_risk_i,
   input  logic [LANES-1:0]        rdata_valid_i,
   input  logic [XLEN*LANES-1:0]   rdata_i,
   output logic [LANES-1:0]        rf_we_o,
   output logic [5*LANES-1:0]      rf_wnum_o,
   output logic [XLEN*LANES-1:0]   rf_wdata_o,
   output logic                    wb_pending_o,
   output logic                    wb_risk_o
`ifdef WB_DEBUG_TRACE_EN
   ,
   output logic [XLEN*LANES-1:0]   debug_wb_pc_o,
   output logic [4*LANES-1:0]      debug_wb_rf_wen_o,
   output logic [5*LANES-1:0]      debug_wb_rf_wnum_o,
   output logic [XLEN*LANES-1:0]   debug_wb_rf_wdata_o
`endif
);

   localparam int unsigned WN_W = 5;

   wb_state_t state_q, state_d;

   logic [LANES-1:0]        en_q;
   logic [WN_W*LANES-1:0]   wnum_q;
   logic [XLEN*LANES-1:0]   res_q;
   logic [XLEN*LANES-1:0]   rt_q;
   logic [2*LANES-1:0]      align_q;
   logic [LSEL_W*LANES-1:0] lsel_q;
   logic [XLEN*LANES-1:0]   pc_q;
   logic [LANES-1:0]        risk_q;
   logic [XLEN*LANES-1:0]   buf_q;
   logic [LANES-1:0]        out_q;

   logic [LANES-1:0] lsel_nz;
   logic             accept;
   logic             retire;

   // State register and held bundle fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WB_EMPTY;
         en_q    <= '0;
         wnum_q  <= '0;
         res_q   <= '0;
         rt_q    <= '0;
         align_q <= '0;
         lsel_q  <= '0;
         pc_q    <= '0;
         risk_q  <= '0;
         buf_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         if (flush_i) begin
            out_q <= '0;
         end else if (accept) begin
            en_q    <= mem_lane_en_i;
            wnum_q  <= mem_wnum_i;
            res_q   <= mem_res_i;
            rt_q    <= mem_rt_i;
            align_q <= mem_align_i;
            lsel_q  <= mem_lsel_i;
            pc_q    <= mem_pc_i;
            risk_q  <= mem_risk_i;
            for (int i = 0; i < LANES; i++) begin
               buf_q[i*XLEN +: XLEN] <= rdata_valid_i[i] ? rdata_i[i*XLEN +: XLEN] : '0;
               out_q[i] <= mem_lane_en_i[i] & lsel_nz[i] & ~rdata_valid_i[i];
            end
         end else if (state_q == WB_WAIT) begin
            // Only the first return per outstanding lane is kept.
            for (int i = 0; i < LANES; i++) begin
               if (out_q[i] && rdata_valid_i[i]) begin
                  buf_q[i*XLEN +: XLEN] <= rdata_i[i*XLEN +: XLEN];
                  out_q[i]              <= 1'b0;
               end
            end
         end
      end
   end

   // Next state, handshake and regfile write enables.
   always_comb begin
      state_d      = state_q;
      lsel_nz      = '0;
      wb_allowin_o = 1'b0;
      accept       = 1'b0;
      retire       = 1'b0;
      rf_we_o      = '0;

      for (int i = 0; i < LANES; i++) begin
         lsel_nz[i] = |mem_lsel_i[i*LSEL_W +: LSEL_W];
      end

      wb_allowin_o = ~flush_i & ((state_q == WB_EMPTY) |
                                 ((state_q == WB_READY) & down_allowin_i));
      accept       = mem_valid_i & wb_allowin_o;
      retire       = (state_q == WB_READY) & down_allowin_i & ~flush_i;

      if (flush_i) begin
         state_d = WB_EMPTY;
      end else if (accept) begin
         state_d = |(mem_lane_en_i & lsel_nz & ~rdata_valid_i) ? WB_WAIT : WB_READY;
      end else begin
         case (state_q)
            WB_WAIT:  if ((out_q & ~rdata_valid_i) == '0) state_d = WB_READY;
            WB_READY: if (down_allowin_i) state_d = WB_EMPTY;
            default:  state_d = state_q;
         endcase
      end

      // Younger lane wins when two lanes target the same register.
      for (int i = 0; i < LANES; i++) begin
         rf_we_o[i] = retire & en_q[i] & (wnum_q[i*WN_W +: WN_W] != '0);
         for (int j = i + 1; j < LANES; j++) begin
            if (en_q[j] && (wnum_q[j*WN_W +: WN_W] == wnum_q[i*WN_W +: WN_W])) begin
               rf_we_o[i] = 1'b0;
            end
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      wb_load_align #(
         .XLEN   (XLEN),
         .LSEL_W (LSEL_W)
      ) u_align (
         .lsel    (lsel_q[g*LSEL_W +: LSEL_W]),
         .align   (align_q[g*2 +: 2]),
         .rdata   (buf_q[g*XLEN +: XLEN]),
         .rt      (rt_q[g*XLEN +: XLEN]),
         .res     (res_q[g*XLEN +: XLEN]),
         .wdata_c (rf_wdata_o[g*XLEN +: XLEN])
      );
   end

   assign rf_wnum_o    = wnum_q;
   assign wb_pending_o = (state_q == WB_WAIT);
   assign wb_risk_o    = |(en_q & risk_q);

`ifdef WB_DEBUG_TRACE_EN
   // Retirement trace, one cycle behind the regfile write.
   always_ff @(posedge clk) begin
      if (rst) begin
         debug_wb_pc_o       <= '0;
         debug_wb_rf_wen_o   <= '0;
         debug_wb_rf_wnum_o  <= '0;
         debug_wb_rf_wdata_o <= '0;
      end else begin
         debug_wb_pc_o       <= pc_q;
         debug_wb_rf_wnum_o  <= wnum_q;
         debug_wb_rf_wdata_o <= rf_wdata_o;
         for (int i = 0; i < LANES; i++) begin
            debug_wb_rf_wen_o[i*4 +: 4] <= {4{rf_we_o[i]}};
         end
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^pc_q;
`endif

endmodule

// File: doc/writeback_nway.md
WRITEBACK_NWAY -- requirements
Module: writeback_nway

Interface
REQ-001 SHALL provide parameter LANES, default 2, number of writeback lanes per bundle (1..4).
REQ-002 SHALL provide parameter XLEN, default 32, datapath width.
REQ-003 SHALL provide parameter LSEL_W, default from shared package, one-hot load-select width.
REQ-004 SHALL provide ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  discard held bundle.
- mem_valid_i  in  1  upstream bundle valid.
- wb_allowin_o  out  1  bundle accepted this cycle when high with mem_valid_i.
- down_allowin_i  in  1  commit side can retire.
- mem_lane_en_i  in  LANES  per-lane instruction present.
- mem_wnum_i  in  5*LANES  destination GPR, 0 = no write.
- mem_res_i  in  XLEN*LANES  non-load result.
- mem_rt_i  in  XLEN*LANES  old rt value for LWL/LWR merge.
- mem_align_i  in  2*LANES  address low bits.
- mem_lsel_i  in  LSEL_W*LANES  load select, all-zero = not a load.
- mem_pc_i  in  XLEN*LANES  lane PC.
- mem_risk_i  in  LANES  lane carries exception risk.
- rdata_valid_i  in  LANES  load data returned for lane.
- rdata_i  in  XLEN*LANES  load data per lane.
- rf_we_o  out  LANES  regfile write enable.
- rf_wnum_o  out  5*LANES  write address.
- rf_wdata_o  out  XLEN*LANES  write data; also forwarding data.
- wb_pending_o  out  1  held bundle has an unfinished load.
- wb_risk_o  out  1  OR of held lanes' risk.

Function
REQ-005 SHALL hold one bundle in states EMPTY, WAIT (≥1 load lane lacks data), READY.
REQ-006 SHALL assert wb_allowin_o = EMPTY or (READY and down_allowin_i); accept on mem_valid_i & wb_allowin_o.
REQ-007 On accept, SHALL go WAIT if any enabled lane has nonzero lsel and rdata_valid_i not high for it that cycle, else READY.
REQ-008 SHALL capture rdata_i per lane into a lane buffer on the first rdata_valid_i while that lane's data is outstanding; later pulses for that lane ignored until next accept.
REQ-009 SHALL leave WAIT for READY the cycle after the last outstanding lane data is captured.
REQ-010 In READY with down_allowin_i high and no new bundle, SHALL go EMPTY next cycle.
REQ-011 SHALL extract load data per lane: LB/LBU byte by align, LH/LHU halfword by align[1], LW word, LWL/LWR merge with mem_rt_i; sign-extend only LB/LH.
REQ-012 SHALL drive rf_wdata_o combinationally from held fields (zero extra latency in READY).
REQ-013 SHALL assert rf_we_o[i] only in READY, down_allowin_i high, lane enabled, wnum nonzero.
REQ-014 When lanes i<j in one bundle share wnum, SHALL suppress rf_we_o[i] (younger lane wins).
REQ-015 flush_i SHALL force EMPTY next cycle, drop outstanding loads, and deassert rf_we_o that cycle; flush has priority over accept.
REQ-016 wb_pending_o SHALL be high exactly in WAIT.

Reset
REQ-017 On rst, state SHALL be EMPTY; all held fields, lane buffers, and outputs zero; wb_allowin_o high the first cycle after reset deasserts.
REQ-018 rst mid-WAIT SHALL abandon the bundle; late rdata_valid_i SHALL be ignored.

Configuration
REQ-019 With WB_DEBUG_TRACE_EN defined, SHALL add registered debug_wb_pc_o, debug_wb_rf_wen_o (4 bits/lane), debug_wb_rf_wnum_o, debug_wb_rf_wdata_o per lane, one cycle after retirement, zero on reset; without it those ports and registers SHALL be absent.

Structure
REQ-020 Shared package SHALL hold load-select bit indices, LSEL_W, and state encoding.
REQ-021 Per-lane load alignment SHALL be sub-module wb_load_align, instantiated LANES times.

Verification
REQ-022 Lane0 ADD wnum=3 res=0x11, lane1 none -> next READY cycle rf_we_o=01, wdata0=0x11, state EMPTY after.
REQ-023 Lane1 LB align=2, rdata=0x00800000 arriving 3 cycles late -> wb_pending_o high 3 cycles, then wdata1=0xFFFFFF80.
REQ-024 Both lanes wnum=5 -> rf_we_o=10, only lane1 writes.
REQ-025 READY with down_allowin_i low 4 cycles -> outputs stable, wb_allowin_o low, no write until release.
REQ-026 flush_i during WAIT, then rdata_valid_i -> EMPTY, no write, no capture.
REQ-027 LWL align=1, rdata=0xAABBCCDD, rt=0x11223344 -> wdata=0xCCDD3344.
